// File: rtl/sa_pkg.sv
// Shared definitions for the systolic-array edge feeders and PEs.
package sa_pkg;

   typedef enum logic [0:0] {
      IDLE   = 1'b0,
      STREAM = 1'b1
   } feeder_state_e;

   localparam int SA_BIT_WIDTH = 16;

   // Beats needed to drain a tile: the last lane starts (CHANNELS-1)*SKEW beats late.
   function automatic int beat_count(input int channels, input int length, input int skew);
      return length + (channels - 1) * skew;
   endfunction

endpackage

// File: rtl/sa_feeder_lane.sv
// One feeder lane: holds a lane slice and presents its current head element.
module sa_feeder_lane
   import sa_pkg::*;
#(
   parameter int LENGTH    = 32,
   parameter int BIT_WIDTH = SA_BIT_WIDTH
) (
   input  logic                        clk_i,
   input  logic                        rst_ni,
   input  logic                        load_i,
   input  logic                        shift_i,
   input  logic [LENGTH*BIT_WIDTH-1:0] slice_i,
   output logic [BIT_WIDTH-1:0]        head_o
);

   logic [LENGTH*BIT_WIDTH-1:0] data_q, data_d;

   // Element 0 lives in the most-significant slot, so advancing is a left shift.
   always_comb begin
      data_d = data_q;
      if (load_i) begin
         data_d = slice_i;
      end else if (shift_i) begin
         data_d = data_q << BIT_WIDTH;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         data_q <= '0;
      end else begin
         data_q <= data_d;
      end
   end

   assign head_o = data_q[LENGTH*BIT_WIDTH-1 -: BIT_WIDTH];

endmodule

// File: rtl/sa_skew_feeder.sv
// Multi-lane tile feeder: accepts a whole tile, then streams one element per lane
// per beat with lane c delayed c*SKEW beats. Handshake: a tile transfers on a
// rising edge where load_valid && load_ready; the source holds load_valid until then.
module sa_skew_feeder
   import sa_pkg::*;
#(
   parameter int CHANNELS  = 8,
   parameter int LENGTH    = 32,
   parameter int BIT_WIDTH = SA_BIT_WIDTH,
   parameter int SKEW      = 1
) (
   input  logic                                 clk,
   input  logic                                 rst_n,
   input  logic                                 load_valid,
   output logic                                 load_ready,
   input  logic [CHANNELS*LENGTH*BIT_WIDTH-1:0] load_data,
   input  logic                                 stall,
   output logic [CHANNELS*BIT_WIDTH-1:0]        out_data,
   output logic [CHANNELS-1:0]                  out_valid,
   output logic                                 busy,
   output logic                                 done,
   output feeder_state_e                        dbg_state_o
);

   localparam int T  = beat_count(CHANNELS, LENGTH, SKEW);
   localparam int CW = $clog2(T + 1);
   localparam logic [CW-1:0] T_LAST = CW'(T - 1);

   feeder_state_e state_q, state_d;
   logic [CW-1:0] t_q, t_d;
   logic          done_q, done_d;
   logic          load_en;
   logic          advance;

   always_comb begin
      state_d = state_q;
      t_d     = t_q;
      done_d  = 1'b0;
      load_en = 1'b0;
      advance = 1'b0;
      case (state_q)
         IDLE: begin
            if (load_valid) begin
               load_en = 1'b1;
               t_d     = '0;
               state_d = STREAM;
            end
         end
         STREAM: begin
            if (!stall) begin
               advance = 1'b1;
               if (t_q == T_LAST) begin
                  t_d     = '0;
                  state_d = IDLE;
                  done_d  = 1'b1;
               end else begin
                  t_d = t_q + 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         t_q     <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         t_q     <= t_d;
         done_q  <= done_d;
      end
   end

   assign load_ready  = (state_q == IDLE);
   assign busy        = (state_q == STREAM);
   assign done        = done_q;
   assign dbg_state_o = state_q;

   for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
      localparam int LO = c * SKEW;
      logic                 active;
      logic [BIT_WIDTH-1:0] head;

      assign active = (state_q == STREAM) && (int'(t_q) >= LO) && (int'(t_q) < LO + LENGTH);

      // Only active lanes shift, so a late lane still holds element 0 when it starts.
      sa_feeder_lane #(
         .LENGTH   (LENGTH),
         .BIT_WIDTH(BIT_WIDTH)
      ) u_lane (
         .clk_i  (clk),
         .rst_ni (rst_n),
         .load_i (load_en),
         .shift_i(advance && active),
         .slice_i(load_data[(c+1)*LENGTH*BIT_WIDTH-1 -: LENGTH*BIT_WIDTH]),
         .head_o (head)
      );

      assign out_data[(c+1)*BIT_WIDTH-1 -: BIT_WIDTH] = active ? head : '0;
      assign out_valid[c] = active;
   end

endmodule

// File: tb/tb_sa_skew_feeder.sv
// Directed bench for sa_skew_feeder: small skewed and unskewed tiles plus the default 8x32x16 configuration.
module tb_sa_skew_feeder;
   import sa_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n, c_rst_n;
   int   n_vec = 0;
   int   n_err = 0;

   // Instance A: 2 lanes x 3 elements x 8 bits, skewed
   logic          a_lv, a_lr, a_stall, a_busy, a_done;
   logic [47:0]   a_ld;
   logic [15:0]   a_od;
   logic [1:0]    a_ov;
   feeder_state_e a_st;

   // Instance B: same shape, no skew
   logic          b_lv, b_lr, b_stall, b_busy, b_done;
   logic [47:0]   b_ld;
   logic [15:0]   b_od;
   logic [1:0]    b_ov;
   feeder_state_e b_st;

   // Instance C: default 8 x 32 x 16, skewed
   logic          c_lv, c_lr, c_stall, c_busy, c_done;
   logic [4095:0] c_ld;
   logic [127:0]  c_od;
   logic [7:0]    c_ov;
   feeder_state_e c_st;

   localparam logic [47:0] TILE1 = {8'd4, 8'd5, 8'd6, 8'd1, 8'd2, 8'd3};
   localparam logic [47:0] TILE2 = {8'd10, 8'd11, 8'd12, 8'd7, 8'd8, 8'd9};

   sa_skew_feeder #(.CHANNELS(2), .LENGTH(3), .BIT_WIDTH(8), .SKEW(1)) u_a (
      .clk(clk), .rst_n(rst_n), .load_valid(a_lv), .load_ready(a_lr), .load_data(a_ld),
      .stall(a_stall), .out_data(a_od), .out_valid(a_ov), .busy(a_busy), .done(a_done),
      .dbg_state_o(a_st));

   sa_skew_feeder #(.CHANNELS(2), .LENGTH(3), .BIT_WIDTH(8), .SKEW(0)) u_b (
      .clk(clk), .rst_n(rst_n), .load_valid(b_lv), .load_ready(b_lr), .load_data(b_ld),
      .stall(b_stall), .out_data(b_od), .out_valid(b_ov), .busy(b_busy), .done(b_done),
      .dbg_state_o(b_st));

   sa_skew_feeder u_c (
      .clk(clk), .rst_n(c_rst_n), .load_valid(c_lv), .load_ready(c_lr), .load_data(c_ld),
      .stall(c_stall), .out_data(c_od), .out_valid(c_ov), .busy(c_busy), .done(c_done),
      .dbg_state_o(c_st));

   // Reference model for the 8x32 tile: element k of lane c is base + c*256 + k + 1.
   function automatic logic [4095:0] c_tile(input int base);
      logic [4095:0] t;
      t = '0;
      for (int c = 0; c < 8; c++)
         for (int k = 0; k < 32; k++)
            t[(c+1)*512-1-k*16 -: 16] = 16'(base + c*256 + k + 1);
      return t;
   endfunction

   function automatic logic [127:0] c_exp_data(input int beat, input int base);
      logic [127:0] e;
      e = '0;
      for (int c = 0; c < 8; c++)
         if (beat - c >= 0 && beat - c < 32) e[(c+1)*16-1 -: 16] = 16'(base + c*256 + (beat - c) + 1);
      return e;
   endfunction

   function automatic logic [7:0] c_exp_valid(input int beat);
      logic [7:0] v;
      v = '0;
      for (int c = 0; c < 8; c++)
         if (beat - c >= 0 && beat - c < 32) v[c] = 1'b1;
      return v;
   endfunction

   task automatic test_reset();
      rst_n = 1'b0; c_rst_n = 1'b0;
      a_lv = 0; a_stall = 0; a_ld = '0;
      b_lv = 0; b_stall = 0; b_ld = '0;
      c_lv = 0; c_stall = 0; c_ld = '0;
      @(negedge clk);
      n_vec++; if (a_od !== 16'h0 || a_ov !== 2'b00) begin n_err++; $display("FAIL reset_a_out got %h/%b want 0000/00", a_od, a_ov); end
      n_vec++; if (a_busy !== 1'b0 || a_done !== 1'b0) begin n_err++; $display("FAIL reset_a_flags got busy=%b done=%b want 0/0", a_busy, a_done); end
      n_vec++; if (c_od !== 128'h0 || c_ov !== 8'h00) begin n_err++; $display("FAIL reset_c_out got %h/%h want 0/0", c_od, c_ov); end
      rst_n = 1'b1; c_rst_n = 1'b1;
      @(negedge clk);
      n_vec++; if (a_lr !== 1'b1 || b_lr !== 1'b1 || c_lr !== 1'b1) begin n_err++; $display("FAIL reset_ready got %b%b%b want 111", a_lr, b_lr, c_lr); end
      n_vec++; if (a_st !== IDLE || c_st !== IDLE) begin n_err++; $display("FAIL reset_state got %0d/%0d want IDLE", a_st, c_st); end
   endtask

   task automatic test_basic();
      logic [15:0] exp_d [5] = '{16'h0001, 16'h0402, 16'h0503, 16'h0600, 16'h0000};
      logic [1:0]  exp_v [5] = '{2'b01, 2'b11, 2'b11, 2'b10, 2'b00};
      a_ld = TILE1; a_lv = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         a_lv = 1'b0;
         n_vec++; if (a_od !== exp_d[i]) begin n_err++; $display("FAIL basic_data obs %0d got %h want %h", i, a_od, exp_d[i]); end
         n_vec++; if (a_ov !== exp_v[i]) begin n_err++; $display("FAIL basic_valid obs %0d got %b want %b", i, a_ov, exp_v[i]); end
         n_vec++; if (a_done !== (i == 4)) begin n_err++; $display("FAIL basic_done obs %0d got %b want %b", i, a_done, (i == 4)); end
         n_vec++; if (a_lr !== (i == 4) || a_busy !== (i != 4)) begin n_err++; $display("FAIL basic_ready_busy obs %0d got %b/%b", i, a_lr, a_busy); end
      end
      @(negedge clk);
      n_vec++; if (a_done !== 1'b0) begin n_err++; $display("FAIL basic_done_width got %b want 0", a_done); end
   endtask

   task automatic test_stall();
      logic [15:0] exp_d [8] = '{16'h0001, 16'h0402, 16'h0402, 16'h0402, 16'h0402, 16'h0503, 16'h0600, 16'h0000};
      logic [1:0]  exp_v [8] = '{2'b01, 2'b11, 2'b11, 2'b11, 2'b11, 2'b11, 2'b10, 2'b00};
      logic        stl   [8] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      a_ld = TILE1; a_lv = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         a_lv = 1'b0;
         n_vec++; if (a_od !== exp_d[i]) begin n_err++; $display("FAIL stall_data obs %0d got %h want %h", i, a_od, exp_d[i]); end
         n_vec++; if (a_ov !== exp_v[i]) begin n_err++; $display("FAIL stall_valid obs %0d got %b want %b", i, a_ov, exp_v[i]); end
         n_vec++; if (a_done !== (i == 7)) begin n_err++; $display("FAIL stall_done obs %0d got %b want %b", i, a_done, (i == 7)); end
         a_stall = stl[i];
      end
      a_stall = 1'b0;
   endtask

   task automatic test_ignore_load();
      logic [15:0] exp_d [5] = '{16'h0001, 16'h0402, 16'h0503, 16'h0600, 16'h0000};
      logic [1:0]  exp_v [5] = '{2'b01, 2'b11, 2'b11, 2'b10, 2'b00};
      a_ld = TILE1; a_lv = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         a_lv = (i < 2);
         a_ld = TILE2;
         n_vec++; if (a_od !== exp_d[i]) begin n_err++; $display("FAIL ignore_data obs %0d got %h want %h", i, a_od, exp_d[i]); end
         n_vec++; if (a_ov !== exp_v[i]) begin n_err++; $display("FAIL ignore_valid obs %0d got %b want %b", i, a_ov, exp_v[i]); end
      end
      a_lv = 1'b0;
      @(negedge clk);
      n_vec++; if (a_busy !== 1'b0 || a_ov !== 2'b00) begin n_err++; $display("FAIL ignore_no_reload got busy=%b valid=%b want 0/00", a_busy, a_ov); end
   endtask

   task automatic test_back_to_back();
      logic [15:0] exp_d [10] = '{16'h0001, 16'h0402, 16'h0503, 16'h0600, 16'h0000,
                                  16'h0007, 16'h0A08, 16'h0B09, 16'h0C00, 16'h0000};
      logic [1:0]  exp_v [10] = '{2'b01, 2'b11, 2'b11, 2'b10, 2'b00, 2'b01, 2'b11, 2'b11, 2'b10, 2'b00};
      a_ld = TILE1; a_lv = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         a_lv = 1'b0;
         n_vec++; if (a_od !== exp_d[i]) begin n_err++; $display("FAIL b2b_data obs %0d got %h want %h", i, a_od, exp_d[i]); end
         n_vec++; if (a_ov !== exp_v[i]) begin n_err++; $display("FAIL b2b_valid obs %0d got %b want %b", i, a_ov, exp_v[i]); end
         n_vec++; if (a_done !== (i == 4 || i == 9)) begin n_err++; $display("FAIL b2b_done obs %0d got %b want %b", i, a_done, (i == 4 || i == 9)); end
         if (i == 4) begin a_ld = TILE2; a_lv = 1'b1; end
      end
   endtask

   task automatic test_no_skew();
      logic [15:0] exp_d [5] = '{16'h0401, 16'h0502, 16'h0603, 16'h0000, 16'h0000};
      logic [1:0]  exp_v [5] = '{2'b11, 2'b11, 2'b11, 2'b00, 2'b00};
      int          full_cnt;
      full_cnt = 0;
      b_ld = TILE1; b_lv = 1'b1; b_stall = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         b_lv = 1'b0; b_stall = 1'b0;
         if (b_ov == 2'b11) full_cnt++;
         n_vec++; if (b_od !== exp_d[i]) begin n_err++; $display("FAIL noskew_data obs %0d got %h want %h", i, b_od, exp_d[i]); end
         n_vec++; if (b_ov !== exp_v[i]) begin n_err++; $display("FAIL noskew_valid obs %0d got %b want %b", i, b_ov, exp_v[i]); end
         n_vec++; if (b_done !== (i == 3)) begin n_err++; $display("FAIL noskew_done obs %0d got %b want %b", i, b_done, (i == 3)); end
      end
      n_vec++; if (full_cnt !== 3) begin n_err++; $display("FAIL noskew_full_count got %0d want 3", full_cnt); end
   endtask

   task automatic test_reset_midstream();
      c_ld = c_tile(0); c_lv = 1'b1;
      for (int b = 0; b < 3; b++) begin
         @(negedge clk);
         c_lv = 1'b0;
         n_vec++; if (c_od !== c_exp_data(b, 0)) begin n_err++; $display("FAIL rst_pre_data beat %0d got %h want %h", b, c_od, c_exp_data(b, 0)); end
         n_vec++; if (c_ov !== c_exp_valid(b)) begin n_err++; $display("FAIL rst_pre_valid beat %0d got %b want %b", b, c_ov, c_exp_valid(b)); end
      end
      #2 c_rst_n = 1'b0;
      #1;
      n_vec++; if (c_od !== 128'h0 || c_ov !== 8'h00) begin n_err++; $display("FAIL rst_async_out got %h/%b want 0/0", c_od, c_ov); end
      n_vec++; if (c_busy !== 1'b0 || c_done !== 1'b0) begin n_err++; $display("FAIL rst_async_flags got busy=%b done=%b want 0/0", c_busy, c_done); end
      @(negedge clk);
      c_rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         n_vec++; if (c_lr !== 1'b1 || c_done !== 1'b0) begin n_err++; $display("FAIL rst_after ready=%b done=%b want 1/0", c_lr, c_done); end
      end
      c_ld = c_tile(16'h4000); c_lv = 1'b1;
      for (int b = 0; b < 40; b++) begin
         @(negedge clk);
         c_lv = 1'b0;
         n_vec++; if (c_od !== c_exp_data(b, 16'h4000)) begin n_err++; $display("FAIL fresh_data beat %0d got %h want %h", b, c_od, c_exp_data(b, 16'h4000)); end
         n_vec++; if (c_ov !== c_exp_valid(b)) begin n_err++; $display("FAIL fresh_valid beat %0d got %b want %b", b, c_ov, c_exp_valid(b)); end
         n_vec++; if (c_done !== (b == 39)) begin n_err++; $display("FAIL fresh_done beat %0d got %b want %b", b, c_done, (b == 39)); end
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_basic();
      test_stall();
      test_ignore_load();
      test_back_to_back();
      test_no_skew();
      test_reset_midstream();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
